// File: rtl/pipe_ctrl_sched_pkg.sv
// rtl/pipe_ctrl_sched_pkg.sv - stall bus type, stall codes, FSM states and priority encoder
package pipe_ctrl_sched_pkg;

  typedef logic [5:0] stall_bus_t;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_IF   = 6'b000011;
  localparam stall_bus_t STALL_LOAD = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_WAIT_MEM = 2'd1,
    CTRL_FLUSH    = 2'd2
  } ctrl_state_e;

  // Deepest stalling stage wins: its code freezes every stage upstream of it.
  function automatic stall_bus_t stall_prio(input logic req_if, input logic req_load,
                                            input logic req_ex, input logic req_mem);
    stall_bus_t code;
    if (req_mem)       code = STALL_MEM;
    else if (req_ex)   code = STALL_EX;
    else if (req_load) code = STALL_LOAD;
    else if (req_if)   code = STALL_IF;
    else               code = STALL_NONE;
    return code;
  endfunction

endpackage

// File: rtl/ctrl_stall_watchdog.sv
// rtl/ctrl_stall_watchdog.sv - saturating stalled-cycle counter with sticky timeout flag
module ctrl_stall_watchdog #(
  parameter int STALL_TIMEOUT = 1023,
  parameter int CNT_W         = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_active,
  output logic stall_timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_TIMEOUT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = '0;
    if (stall_active) begin
      cnt_nxt = (cnt == LIMIT) ? cnt : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      stall_timeout <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (cnt_nxt == LIMIT) begin
        stall_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl_sched.sv
// rtl/pipe_ctrl_sched.sv - stall arbitration, redirect flush sequencing, stall watchdog
// Optional perf counters enabled by defining CTRL_PERF_EN.
module pipe_ctrl_sched
  import pipe_ctrl_sched_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1023,
  parameter int CNT_W         = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_for_if,
  input  logic        stallreq_for_load,
  input  logic        stallreq_for_ex,
  input  logic        stallreq_for_mem,
  input  logic        excp_req,
  input  logic [31:0] excp_pc,
  output stall_bus_t  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
`endif
);

  ctrl_state_e state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  stall_bus_t  stall_code;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_q;
    stall_code = stall_prio(stallreq_for_if, stallreq_for_load,
                            stallreq_for_ex, stallreq_for_mem);
    case (state)
      CTRL_RUN: begin
        // Freeze everything up to MEM while the redirect is taken or parked.
        if (excp_req) begin
          stall_code = STALL_MEM;
          if (!stallreq_for_mem) begin
            pc_nxt    = excp_pc;
            state_nxt = CTRL_FLUSH;
          end else begin
            state_nxt = CTRL_WAIT_MEM;
          end
        end
      end
      CTRL_WAIT_MEM: begin
        if (!excp_req) begin
          state_nxt = CTRL_RUN;
        end else if (!stallreq_for_mem) begin
          pc_nxt    = excp_pc;
          state_nxt = CTRL_FLUSH;
        end
      end
      CTRL_FLUSH: begin
        stall_code = STALL_NONE;
        state_nxt  = CTRL_RUN;
      end
      default: begin
        state_nxt = CTRL_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CTRL_RUN;
      pc_q  <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
    end
  end

  assign stall  = rst ? STALL_NONE : stall_code;
  assign flush  = (state == CTRL_FLUSH);
  assign new_pc = flush ? pc_q : 32'd0;

  ctrl_stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT),
    .CNT_W        (CNT_W)
  ) u_watchdog (
    .clk          (clk),
    .rst          (rst),
    .stall_active (stall != STALL_NONE),
    .stall_timeout(stall_timeout)
  );

`ifdef CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall != STALL_NONE) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (flush)               perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
